// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer encodings and byte-lane strobe helper
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;
  typedef enum logic [2:0] {BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010} hsize_e;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01} hresp_e;
  function automatic logic [3:0] strb(input logic [2:0] size, input logic [1:0] a);
    return size == BYTE ? 4'b0001 << a :
           size == HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           size == WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/ahb_slave_ram.sv
// ahb_slave_ram: single-port word RAM, byte write enables, asynchronous read
module ahb_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory slave with programmable wait states and two-cycle ERROR responses
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hselx,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic              Hreadyin,
  input  logic [31:0]       Hwdata,
  output logic [31:0]       Hrdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;
  state_e st;
  logic [3:0] cnt, we;
  logic pend, p_write, accept, legal, done, unused_burst;
  logic [IW+1:0] p_addr;
  logic [2:0] p_size;
  logic [31:0] hold, ram_q;
  assign accept = Hselx && Hreadyin && Hreadyout && (Htrans == NONSEQ || Htrans == SEQ);
  assign legal = Haddr < ADDR_W'(4 * DEPTH_WORDS) && Hsize <= WORD &&
                 !(Hsize == HALF && Haddr[0]) && !(Hsize == WORD && Haddr[1:0] != 2'b00);
  // pend marks a legal beat in its data phase; it completes on the first cycle Hreadyout is high
  assign done = pend && Hreadyout;
  assign we = done && p_write ? strb(p_size, p_addr[1:0]) : 4'b0000;
  assign Hrdata = done && !p_write ? ram_q : hold;
  assign unused_burst = ^Hburst;
  ahb_slave_ram #(.DEPTH(DEPTH_WORDS), .AW(IW)) u_ram (
    .clk(Hclk),
    .we(we),
    .addr(p_addr[IW+1:2]),
    .wdata(Hwdata),
    .rdata(ram_q)
  );
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      st <= ST_IDLE;
      cnt <= 4'd0;
      pend <= 1'b0;
      p_write <= 1'b0;
      p_addr <= '0;
      p_size <= 3'd0;
      hold <= 32'd0;
      Hreadyout <= 1'b1;
      Hresp <= OKAY;
    end else begin
      if (done && !p_write) hold <= ram_q;
      if (accept) begin
        p_addr <= Haddr[IW+1:0];
        p_write <= Hwrite;
        p_size <= Hsize;
        pend <= legal;
        cnt <= 4'(WAIT_STATES);
        st <= !legal ? ST_ERR1 : (WAIT_STATES == 0 ? ST_IDLE : ST_WAIT);
        Hreadyout <= legal && WAIT_STATES == 0;
        Hresp <= legal ? OKAY : ERROR;
      end else if (st == ST_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          st <= ST_IDLE;
          Hreadyout <= 1'b1;
        end
      end else if (st == ST_ERR1) begin
        st <= ST_ERR2;
        Hreadyout <= 1'b1;
      end else begin
        st <= ST_IDLE;
        pend <= 1'b0;
        Hreadyout <= 1'b1;
        Hresp <= OKAY;
      end
    end
endmodule
